// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, PC/instruction widths,
// opcode field position and the default halt opcode.
package cpu_pkg;

  localparam int PC_W       = 19;
  localparam int INSTR_W    = 32;
  localparam int RADDR_W    = PC_W - 2;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 5;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 6'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    LATCH,
    EXEC,
    UPDATE,
    HALT,
    PAUSE
  } state_t;

  // Word address of a byte-addressed PC.
  function automatic logic [RADDR_W-1:0] word_addr(input logic [PC_W-1:0] byte_addr);
    return byte_addr[PC_W-1:2];
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] byte_addr);
    return {byte_addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Execute-phase watchdog: counts cycles while enabled and flags expiry once
// the count reaches TIMEOUT_CYCLES-1. The count holds at that value.
module exec_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  assign expired = (count_q == LAST);

  // Cycle counter: cleared before each execute, saturates at expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches from synchronous instruction memory,
// issues run to the decode/execute unit and waits for its ok pulse.
// Optional single-step mode: define FETCH_SEQUENCER_STEP_EN to add the
// step input, the step_wait output and the PAUSE state.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]     RESET_PC       = '0,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE    = DEFAULT_HALT_OPCODE,
  parameter int                  TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               restart,
  output logic [RADDR_W-1:0] IMemory_raddr,
  input  logic [INSTR_W-1:0] IMemory_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    PC,
  output logic               run,
  input  logic               ok,
  input  logic [INSTR_W-1:0] PC_wdata,
  input  logic               PC_wren,
`ifdef FETCH_SEQUENCER_STEP_EN
  input  logic               step,
  output logic               step_wait,
`endif
  output logic               halted,
  output logic               fault,
  output logic [31:0]        retired
);

  state_t             state_q, state_d;
  logic               redir_pending;
  logic [RADDR_W-1:0] target_q;
  logic               wd_clear, wd_enable, wd_expired;
  logic               is_halt_word;

  // Upper redirect bits lie outside the 19-bit address space.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^PC_wdata[INSTR_W-1:PC_W];

  assign is_halt_word = (IMemory_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign wd_clear     = (state_q == LATCH);
  assign wd_enable    = (state_q == EXEC);

  exec_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_exec_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ok has priority over the watchdog in EXEC.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = ADDR;
      ADDR:   state_d = WAIT;
      WAIT:   state_d = LATCH;
      LATCH:  state_d = is_halt_word ? HALT : EXEC;
      EXEC: begin
        if (ok)              state_d = UPDATE;
        else if (wd_expired) state_d = HALT;
      end
`ifdef FETCH_SEQUENCER_STEP_EN
      UPDATE: state_d = start ? PAUSE : IDLE;
      PAUSE: begin
        if (!start)    state_d = IDLE;
        else if (step) state_d = ADDR;
      end
`else
      UPDATE: state_d = start ? ADDR : IDLE;
      PAUSE:  state_d = IDLE;
`endif
      HALT:   if (restart) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; run/halted follow the next state so
  // they change on the same edge as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IMemory_raddr <= word_addr(RESET_PC);
      PC            <= align_pc(RESET_PC);
      instr         <= '0;
      run           <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      retired       <= '0;
      redir_pending <= 1'b0;
      target_q      <= '0;
`ifdef FETCH_SEQUENCER_STEP_EN
      step_wait     <= 1'b0;
`endif
    end else begin
      run    <= (state_d == EXEC);
      halted <= (state_d == HALT);
`ifdef FETCH_SEQUENCER_STEP_EN
      step_wait <= (state_d == PAUSE);
`endif
      case (state_q)
        ADDR: IMemory_raddr <= word_addr(PC);
        LATCH: begin
          instr         <= IMemory_rdata;
          redir_pending <= 1'b0;
        end
        EXEC: begin
          // A strobe in the same cycle as ok still applies to this instruction.
          if (PC_wren) begin
            target_q      <= word_addr(PC_wdata[PC_W-1:0]);
            redir_pending <= 1'b1;
          end
          if (ok)              retired <= retired + 32'd1;
          else if (wd_expired) fault   <= 1'b1;
        end
        UPDATE: begin
          PC            <= redir_pending ? {target_q, 2'b00} : PC + PC_W'(4);
          redir_pending <= 1'b0;
        end
        HALT: begin
          if (restart) begin
            PC    <= align_pc(RESET_PC);
            fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// instruction stream, checked against a PC-walk model of the program.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        ok = 1'b0;
  logic        PC_wren = 1'b0;
  logic [31:0] PC_wdata = '0;
  logic [31:0] IMemory_rdata = '0;
  logic [16:0] IMemory_raddr;
  logic [31:0] instr;
  logic [18:0] PC;
  logic        run, halted, fault;
  logic [31:0] retired;
`ifdef FETCH_SEQUENCER_STEP_EN
  logic        step = 1'b0;
  logic        step_wait;
  bit          auto_step = 1'b1;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [int];   // keyed by word address
  logic [18:0] m_pc = '0;
  logic [31:0] m_retired = '0;

  localparam logic [31:0] HALT_WORD = 32'h0000_00FF;  // opcode 6'h3F

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .restart      (restart),
    .IMemory_raddr(IMemory_raddr),
    .IMemory_rdata(IMemory_rdata),
    .instr        (instr),
    .PC           (PC),
    .run          (run),
    .ok           (ok),
    .PC_wdata     (PC_wdata),
    .PC_wren      (PC_wren),
`ifdef FETCH_SEQUENCER_STEP_EN
    .step         (step),
    .step_wait    (step_wait),
`endif
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [16:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[5:0] = 6'($urandom_range(0, 62));
    return w;
  endfunction

  // Synchronous instruction memory: data follows the address half a cycle later.
  always @(negedge clk) IMemory_rdata = mem_word(IMemory_raddr);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(negedge clk);
`ifdef FETCH_SEQUENCER_STEP_EN
    step = auto_step && step_wait;
`endif
  endtask

  // One instruction: wait for run, check fetch, answer after lat cycles.
  task automatic exec_one(input int lat, input bit redir, input bit same,
                          input logic [31:0] tgt, input int exp_gap, input bit drop);
    int          gap = 0;
    bit          seen = 1'b0;
    logic [18:0] nxt;
    for (int i = 0; i < 200; i++) begin
      tick();
      gap++;
      if (run) begin
        seen = 1'b1;
        break;
      end
    end
    check("run_seen", 32'(seen), 32'd1);
    if (!seen) return;
`ifndef FETCH_SEQUENCER_STEP_EN
    if (exp_gap > 0) check("fetch_gap", gap, exp_gap);
`endif
    check("exec_pc", 32'(PC), 32'(m_pc));
    check("exec_raddr", 32'(IMemory_raddr), 32'(m_pc[18:2]));
    check("exec_instr", instr, mem_word(m_pc[18:2]));
    if (drop) start = 1'b0;
    m_retired = m_retired + 32'd1;
    nxt = redir ? {tgt[18:2], 2'b00} : m_pc + 19'd4;
    for (int c = 1; c < lat; c++) begin
      if (redir && !same && c == lat - 1) begin
        PC_wren  = 1'b1;
        PC_wdata = tgt;
      end
      tick();
      PC_wren  = 1'b0;
      PC_wdata = $urandom;
      check("run_held", 32'(run), 32'd1);
    end
    ok = 1'b1;
    if (redir && (same || lat == 1)) begin
      PC_wren  = 1'b1;
      PC_wdata = tgt;
    end
    tick();
    ok       = 1'b0;
    PC_wren  = 1'b0;
    PC_wdata = $urandom;
    check("run_after_ok", 32'(run), 32'd0);
    check("retired", retired, m_retired);
    tick();
    check("next_pc", 32'(PC), 32'(nxt));
    m_pc = nxt;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 50 && !halted; i++) tick();
    check("halt_seen", 32'(halted), 32'd1);
  endtask

  task automatic do_restart();
    start   = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_pc    = '0;
    check("restart_pc", 32'(PC), 32'd0);
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    int cnt;
    int idle_run;

    // Reset values.
    repeat (2) tick();
    check("rst_run", 32'(run), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_raddr", 32'(IMemory_raddr), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retired", retired, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch of three words, then a halt word at 0xC.
    mem.delete();
    mem[0] = 32'h00A0_0013;
    mem[1] = 32'h0150_0093;
    mem[2] = 32'h0020_8133;
    mem[3] = HALT_WORD;
    start = 1'b1;
    exec_one(5, 1'b0, 1'b0, '0, 4, 1'b0);
    exec_one(5, 1'b0, 1'b0, '0, 3, 1'b0);
    exec_one(5, 1'b0, 1'b0, '0, 3, 1'b0);
    wait_halt();
    check("seq_retired", retired, 32'd3);
    check("seq_pc", 32'(PC), 32'h0000_000C);
    check("seq_run", 32'(run), 32'd0);
    check("seq_instr", instr, HALT_WORD);
    do_restart();

    // Jump redirect from 0x4 to 0x40, strobe one cycle before ok.
    mem.delete();
    mem[0]  = rand_word();
    mem[1]  = rand_word();
    mem[16] = rand_word();
    mem[17] = HALT_WORD;
    start = 1'b1;
    exec_one(3, 1'b0, 1'b0, '0, 4, 1'b0);
    exec_one(4, 1'b1, 1'b0, 32'h0000_0040, 3, 1'b0);
    tick();
    check("jump_raddr", 32'(IMemory_raddr), 32'h0000_0010);
    exec_one(2, 1'b0, 1'b0, '0, 0, 1'b0);
    wait_halt();
    check("jump_halt_pc", 32'(PC), 32'h0000_0044);
    do_restart();

    // Same-cycle redirect; unaligned target with junk upper bits lands on 0x8.
    mem.delete();
    mem[0] = rand_word();
    mem[2] = HALT_WORD;
    start = 1'b1;
    exec_one(3, 1'b1, 1'b1, 32'hABC8_000B, 4, 1'b0);
    wait_halt();
    check("same_cycle_pc", 32'(PC), 32'h0000_0008);
    do_restart();

    // Wrap 0x7FFFC -> 0x0, with start dropped during the last execute.
    mem.delete();
    mem[0]       = rand_word();
    mem[17'h1FFFF] = rand_word();
    start = 1'b1;
    exec_one(2, 1'b0 | 1'b1, 1'b0, 32'h0007_FFFC, 4, 1'b0);
    exec_one(3, 1'b0, 1'b0, '0, 3, 1'b1);
    idle_run = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (run) idle_run++;
    end
    check("wrap_idle_run", idle_run, 0);
    check("wrap_pc", 32'(PC), 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);

    // ok/PC_wren outside EXEC are ignored.
    ok = 1'b1; PC_wren = 1'b1; PC_wdata = 32'h0000_0100;
    repeat (2) tick();
    ok = 1'b0; PC_wren = 1'b0;
    check("idle_ok_retired", retired, m_retired);
    check("idle_wren_pc", 32'(PC), 32'(m_pc));

    // Timeout: ok never arrives.
    start = 1'b1;
    for (int i = 0; i < 20 && !run; i++) tick();
    check("to_run_seen", 32'(run), 32'd1);
    cnt = 0;
    while (run && cnt < 200) begin
      cnt++;
      tick();
    end
    check("to_run_cycles", cnt, 64);
    check("to_fault", 32'(fault), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_retired", retired, m_retired);
    do_restart();
    repeat (3) tick();
    check("to_idle_run", 32'(run), 32'd0);
    check("to_idle_halted", 32'(halted), 32'd0);

    // Random instruction stream against the PC-walk model.
    mem.delete();
    start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      int   lat;
      bit   rd, sm;
      if (!mem.exists(int'(m_pc[18:2]))) mem[int'(m_pc[18:2])] = rand_word();
      lat = $urandom_range(1, 8);
      rd  = ($urandom_range(0, 3) == 0);
      sm  = 1'($urandom_range(0, 1));
      exec_one(lat, rd, sm, $urandom, (i == 0) ? 4 : 3, (i == 24));
    end
    repeat (6) tick();
    check("rand_idle_run", 32'(run), 32'd0);
    check("rand_pc", 32'(PC), 32'(m_pc));
    check("rand_retired", retired, m_retired);

    // Asynchronous reset while run is high.
    if (!mem.exists(int'(m_pc[18:2]))) mem[int'(m_pc[18:2])] = rand_word();
    start = 1'b1;
    for (int i = 0; i < 20 && !run; i++) tick();
    check("ar_run_before", 32'(run), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_run", 32'(run), 32'd0);
    check("ar_pc", 32'(PC), 32'd0);
    check("ar_retired", retired, 32'd0);
    m_pc = '0;
    m_retired = '0;
    mem[0] = rand_word();
    tick();
    rst_n = 1'b1;
    exec_one(2, 1'b0, 1'b0, '0, 4, 1'b1);
    repeat (4) tick();

`ifdef FETCH_SEQUENCER_STEP_EN
    // Single-step: pause after each instruction until a step pulse.
    begin
      logic [16:0] held_raddr;
      int          bad;
      auto_step = 1'b0;
      start = 1'b1;
      exec_one(3, 1'b0, 1'b0, '0, 0, 1'b0);
      check("step_wait_set", 32'(step_wait), 32'd1);
      held_raddr = IMemory_raddr;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (run || !step_wait || IMemory_raddr !== held_raddr) bad++;
      end
      check("step_hold", bad, 0);
      if (!mem.exists(int'(m_pc[18:2]))) mem[int'(m_pc[18:2])] = rand_word();
      step = 1'b1;
      exec_one(2, 1'b0, 1'b0, '0, 0, 1'b0);
      check("step_retired", retired, m_retired);
      check("step_wait_again", 32'(step_wait), 32'd1);
      start = 1'b0;
      tick();
      tick();
      check("step_wait_clear", 32'(step_wait), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
